// File: rtl/fc_mac_pkg.sv
// Shared types, default widths and the result conversion for the FC MAC engine.
// Define FC_MAC_SAT_EN to clamp results to the output range instead of wrapping.
package fc_mac_pkg;

    localparam int DIN0_W = 16;
    localparam int DIN1_W = 16;
    localparam int ACC_W  = 40;
    localparam int DOUT_W = 32;
    localparam int LEN_W  = 10;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // Works on a 64-bit sign-extended sum so any ACC_W up to 64 can share it;
    // the caller keeps the low dout_w bits of the returned value.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc,
                                                     input int dout_w,
                                                     output logic sat);
`ifdef FC_MAC_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi  = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        sat = 1'b0;
        if (acc > hi) begin
            sat = 1'b1;
            return hi;
        end
        if (acc < lo) begin
            sat = 1'b1;
            return lo;
        end
        return acc;
`else
        sat = 1'b0;
        return (acc <<< (64 - dout_w)) >>> (64 - dout_w);
`endif
    endfunction

endpackage

// File: rtl/fc_mac_mul_pipe.sv
// Signed multiplier with STAGES register stages and an enable; the beat tags
// travel alongside the product so they emerge aligned with it.
module fc_mac_mul_pipe
    import fc_mac_pkg::*;
#(
    parameter int A_W    = 16,
    parameter int B_W    = 16,
    parameter int STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic signed [A_W-1:0]    a_i,
    input  logic signed [B_W-1:0]    b_i,
    input  tag_t                     tag_i,
    output logic signed [A_W+B_W-1:0] prod_o,
    output tag_t                     tag_o
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] prod_q [STAGES];
    tag_t                  tag_q  [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (en_i) begin
            prod_q[0] <= P_W'(a_i) * P_W'(b_i);
            tag_q[0]  <= tag_i;
            for (int i = 1; i < STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign prod_o = prod_q[STAGES-1];
    assign tag_o  = tag_q[STAGES-1];

endmodule

// File: rtl/fc_mac_pipe.sv
// Pipelined signed dot-product engine for the FC layers: one operand pair per beat,
// one result per cfg_len beats. FC_MAC_SAT_EN selects saturating output conversion.
module fc_mac_pipe #(
    parameter int DIN0_W     = fc_mac_pkg::DIN0_W,
    parameter int DIN1_W     = fc_mac_pkg::DIN1_W,
    parameter int ACC_W      = fc_mac_pkg::ACC_W,
    parameter int DOUT_W     = fc_mac_pkg::DOUT_W,
    parameter int MUL_STAGES = 2,
    parameter int LEN_W      = fc_mac_pkg::LEN_W
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DIN0_W-1:0] din0,
    input  logic signed [DIN1_W-1:0] din1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     sat_flag
);

    import fc_mac_pkg::*;

    localparam int P_W = DIN0_W + DIN1_W;

    logic                     stall;
    logic                     pipeEn;
    logic                     accept;
    logic                     beatFirst;
    logic                     beatLast;
    logic [LEN_W-1:0]         effLen;
    logic [LEN_W-1:0]         count_q, count_d;
    logic [LEN_W-1:0]         len_q, len_d;
    tag_t                     inTag;
    tag_t                     pipeTag;
    logic signed [P_W-1:0]    pipeProd;
    logic signed [ACC_W-1:0]  prodExt;
    logic signed [ACC_W-1:0]  accSum;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DOUT_W-1:0] dout_q, dout_d;
    logic                     outValid_q, outValid_d;
    logic                     sat_q, sat_d;

    assign stall    = outValid_q && !out_ready;
    assign pipeEn   = !stall;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // The vector length is captured from the first beat only; a zero length counts as one.
    always_comb begin
        count_d   = count_q;
        len_d     = len_q;
        beatFirst = (count_q == '0);
        effLen    = len_q;
        if (beatFirst) begin
            effLen = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        end
        beatLast = (count_q == effLen - LEN_W'(1));
        if (accept) begin
            count_d = beatLast ? '0 : count_q + LEN_W'(1);
            if (beatFirst) begin
                len_d = effLen;
            end
        end
        inTag = '{valid: accept, first: beatFirst, last: beatLast};
    end

    fc_mac_mul_pipe #(
        .A_W    (DIN0_W),
        .B_W    (DIN1_W),
        .STAGES (MUL_STAGES)
    ) u_mul (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .en_i   (pipeEn),
        .a_i    (din0),
        .b_i    (din1),
        .tag_i  (inTag),
        .prod_o (pipeProd),
        .tag_o  (pipeTag)
    );

    // Unless stalled the output register either takes a fresh result or empties.
    always_comb begin
        acc_d      = acc_q;
        dout_d     = dout_q;
        sat_d      = sat_q;
        outValid_d = outValid_q;
        prodExt    = ACC_W'(pipeProd);
        accSum     = pipeTag.first ? prodExt : acc_q + prodExt;
        if (!stall) begin
            outValid_d = 1'b0;
            if (pipeTag.valid) begin
                acc_d = accSum;
                if (pipeTag.last) begin
                    dout_d     = DOUT_W'(sat_trunc(64'(accSum), DOUT_W, sat_d));
                    outValid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            count_q    <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            dout_q     <= '0;
            sat_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            dout_q     <= dout_d;
            sat_q      <= sat_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_valid = outValid_q;
    assign dout      = dout_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fc_mac_pipe.sv
// Directed self-checking bench for fc_mac_pipe with hand-computed dot products,
// covering latency, overflow, backpressure, length rules and mid-vector reset.
module tb_fc_mac_pipe;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [9:0]  cfg_len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din0;
    logic [15:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;
    logic        sat_flag;

    int checks = 0;
    int errors = 0;

    logic [31:0] gotDout[$];
    logic        gotSat[$];

    fc_mac_pipe dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sat_flag  (sat_flag)
    );

    always #5 ap_clk = ~ap_clk;

    // Every completed output handshake is recorded here, half a cycle before its edge.
    always @(negedge ap_clk) begin
        if (out_valid && out_ready) begin
            gotDout.push_back(dout);
            gotSat.push_back(sat_flag);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one beat and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [9:0] len, input int a, input int b);
        int guard;
        guard    = 0;
        cfg_len  = len;
        din0     = 16'(a);
        din1     = 16'(b);
        in_valid = 1'b1;
        @(negedge ap_clk);
        while (!in_ready && guard < 50) begin
            @(negedge ap_clk);
            guard++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expectResult(input string tag, input logic [31:0] expDout, input logic expSat);
        int guard;
        guard = 0;
        while (gotDout.size() == 0 && guard < 40) begin
            @(negedge ap_clk);
            #1;
            guard++;
        end
        if (gotDout.size() == 0) begin
            checkOutput({tag, "_timeout"}, 64'(gotDout.size()), 64'd1);
        end else begin
            checkOutput({tag, "_dout"}, 64'(gotDout.pop_front()), 64'(expDout));
            checkOutput({tag, "_sat"}, 64'(gotSat.pop_front()), 64'(expSat));
        end
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cfg_len   = '0;
        din0      = '0;
        din1      = '0;

        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_dout", 64'(dout), 64'd0);
        checkOutput("rst_sat", 64'(sat_flag), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        $display("[TB] basic dot product");
        applyStimulus(10'd3, 2, 3);
        applyStimulus(10'd3, -4, 5);
        applyStimulus(10'd3, 7, -1);
        checkOutput("lat_t0", 64'(out_valid), 64'd0);
        @(posedge ap_clk);
        #1;
        checkOutput("lat_t1", 64'(out_valid), 64'd0);
        @(posedge ap_clk);
        #1;
        checkOutput("lat_t2", 64'(out_valid), 64'd1);
        expectResult("basic", 32'hFFFF_FFEB, 1'b0);

        $display("[TB] overflow");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(10'd4, -32768, -32768);
        end
`ifdef FC_MAC_SAT_EN
        expectResult("ovf", 32'h7FFF_FFFF, 1'b1);
`else
        expectResult("ovf", 32'h0000_0000, 1'b0);
`endif

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(10'd1, 1, 1);
        applyStimulus(10'd1, 2, 2);
        applyStimulus(10'd1, 3, 3);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_dout_hold", 64'(dout), 64'd1);
            @(posedge ap_clk);
            #1;
        end
        out_ready = 1'b1;
        expectResult("bp_r1", 32'd1, 1'b0);
        expectResult("bp_r2", 32'd4, 1'b0);
        expectResult("bp_r3", 32'd9, 1'b0);
        repeat (5) @(posedge ap_clk);
        #1;
        checkOutput("bp_no_extra", 64'(gotDout.size()), 64'd0);

        $display("[TB] length rules");
        applyStimulus(10'd0, 5, 6);
        expectResult("len_zero", 32'd30, 1'b0);
        applyStimulus(10'd2, 3, 4);
        applyStimulus(10'd5, 5, 6);
        expectResult("len_change", 32'd42, 1'b0);
        applyStimulus(10'd1, 1, 7);
        expectResult("len_next", 32'd7, 1'b0);

        $display("[TB] mid-vector reset");
        applyStimulus(10'd3, 100, 100);
        applyStimulus(10'd3, 100, 100);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checkOutput("mrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("mrst_dout", 64'(dout), 64'd0);
        #2;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        applyStimulus(10'd1, 1, -1);
        expectResult("mrst_new", 32'hFFFF_FFFF, 1'b0);
        repeat (5) @(posedge ap_clk);
        #1;
        checkOutput("mrst_no_extra", 64'(gotDout.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_mac_pipe.md
Name: fc_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate engine for the fully-connected layers of the LeNet-5 accelerator.
- Successor to the single-cycle combinational signed multiplier. It adds configurable operand, product and accumulator widths, configurable multiplier pipeline depth, vector-length counting and valid/ready handshakes.
- Accepts one (activation, weight) pair per cycle and emits one dot-product result per vector of cfg_len terms.
- Sits between the FC weight/activation streamers and the bias/activation stage.

Parameters:
- DIN0_W, 16, activation operand width (signed)
- DIN1_W, 16, weight operand width (signed)
- ACC_W, 40, accumulator width (signed); must be >= DIN0_W+DIN1_W
- DOUT_W, 32, result width (signed); must be <= ACC_W
- MUL_STAGES, 2, register stages in the multiplier, 1..4
- LEN_W, 10, width of the vector-length field

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- cfg_len  in  LEN_W  terms per vector; sampled on the first beat of each vector
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- din0  in  DIN0_W  signed activation
- din1  in  DIN1_W  signed weight
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- dout  out  DOUT_W  signed dot product
- sat_flag  out  1  result was clamped; qualified by out_valid

Behaviour:
- Reset: asynchronous, active-low; reset is the only asynchronous input.
  - Clears every register: pipeline data, first/last tags, valid bits, beat counter, accumulator, output register.
  - After reset: out_valid=0, dout=0, sat_flag=0, in_ready=1.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stalled, the whole pipeline holds and no state changes.
- Beat counter:
  - Counts accepted beats within the current vector.
  - The first beat latches len_q = (cfg_len==0) ? 1 : cfg_len. Changes to cfg_len mid-vector are ignored.
  - A beat is tagged first when count==0 and last when count==len_q-1; a beat can carry both tags.
  - On the last beat the counter returns to 0.
- Multiplier:
  - product = signed(din0)*signed(din1), full DIN0_W+DIN1_W bits.
  - Pipelined MUL_STAGES deep; the first/last tags and a valid bit travel with the data.
- Accumulator (stage after the multiplier, advances only when the pipe is not stalled):
  - On a first-tagged product: acc = sign-extended product.
  - Otherwise: acc = acc + product, wrapping modulo 2^ACC_W.
  - On a last-tagged product: the final sum (acc + product, or the product alone if also first) is converted and loaded into the output register; out_valid=1.
- Latency: the last beat accepted at cycle t gives out_valid=1 at t+MUL_STAGES+1.
- Throughput: one beat per cycle; back-to-back vectors with no bubble.
- Output register:
  - Holds dout and sat_flag stable until out_valid && out_ready.
  - If a new result is arriving in the same cycle as the handshake, it is loaded; otherwise out_valid drops.
- Mid-vector reset: the partial sum is discarded and the next accepted beat starts a new vector.

Optional Feature:
- Macro: FC_MAC_SAT_EN.
- Defined: the ACC_W sum is clamped to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]. sat_flag=1 when clamping occurs.
- Undefined: dout = low DOUT_W bits of the sum (two's-complement wrap); sat_flag is tied to 0.

Decomposition:
- Package fc_mac_pkg holds:
  - default width constants: DIN0_W, DIN1_W, ACC_W, DOUT_W, LEN_W;
  - a tag struct typedef {valid, first, last};
  - a function sat_trunc(acc) implementing both conversion modes.
- Sub-module fc_mac_mul_pipe: signed pipelined multiplier with enable, plus the tag shift chain, parametrised by MUL_STAGES.

Test Plan:
- Basic dot product: cfg_len=3; pairs (2,3), (-4,5), (7,-1), out_ready=1 -> one result dout=-21 (0xFFFFFFEB), sat_flag=0, MUL_STAGES+1 cycles after the third beat.
- Overflow: cfg_len=4; four pairs of (-32768,-32768), sum 2^32.
  - Without macro -> dout=0x00000000.
  - With FC_MAC_SAT_EN -> dout=0x7FFFFFFF, sat_flag=1.
- Backpressure: cfg_len=1; pairs (1,1), (2,2), (3,3) back-to-back; out_ready=0 for 5 cycles -> in_ready=0 while stalled, dout holds 1. After release the results are 1, 4, 9 in order, with nothing lost or duplicated.
- Length rules: cfg_len=0 with pair (5,6) -> treated as length 1, dout=30. Also change cfg_len from 2 to 5 after the first beat of a length-2 vector -> the vector still ends after 2 beats.
- Mid-vector reset: cfg_len=3; accept 2 beats of (100,100); pulse ap_rst_n low asynchronously -> out_valid=0 and in_ready=1 immediately. Then a length-1 vector (1,-1) -> dout=-1.
